// File: rtl/regfile_dbg_pkg.sv
// Shared register-bus types, reset/enable constants and dump-engine state encodings.
package regfile_dbg_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;

  localparam logic      RstEnable   = 1'b1;
  localparam logic      WriteEnable = 1'b1;
  localparam RegBus     ZeroWord    = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr  = 5'd0;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_SEND = 2'd1,
    DBG_DONE = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset/enable gating, hardwired zero, write-through bypass.
module regfile_rdport
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic [DATA_W-1:0] o_rdata
);

  always_comb begin
    o_rdata = DATA_W'(ZeroWord);
    if (i_rst == RstEnable || !i_re) begin
      o_rdata = DATA_W'(ZeroWord);
    end else if (i_raddr == ADDR_W'(NOPRegAddr)) begin
      o_rdata = DATA_W'(ZeroWord);
    end else if (i_we == WriteEnable && i_waddr == i_raddr) begin
      o_rdata = i_wdata;
    end else begin
      o_rdata = i_reg_data;
    end
  end

endmodule

// File: rtl/regfile_dbg.sv
// Two-read/one-write register file with a valid/ready debug dump engine.
//   state    | meaning
//   DBG_IDLE | waiting for i_dbg_start
//   DBG_SEND | presenting beat r_idx, snapshot held in r_data until accepted
//   DBG_DONE | one-cycle completion pulse
module regfile_dbg
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W = $bits(RegBus),
  parameter int ADDR_W = RegNumLog2,
  parameter int NREG   = RegNum
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_dbg_start,
  output logic              o_dbg_busy,
  output logic              o_dbg_valid,
  input  logic              i_dbg_ready,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_dbg_done
);

  logic [DATA_W-1:0] r_regs [NREG];
  dbg_state_e        r_state;
  dbg_state_e        w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_nxt_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we == WriteEnable && i_waddr != ADDR_W'(NOPRegAddr)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
    .i_rst      (i_rst),
    .i_re       (i_re1),
    .i_raddr    (i_raddr1),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
    .i_reg_data (r_regs[i_raddr1]),
    .o_rdata    (o_rdata1)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
    .i_rst      (i_rst),
    .i_re       (i_re2),
    .i_raddr    (i_raddr2),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
    .i_reg_data (r_regs[i_raddr2]),
    .o_rdata    (o_rdata2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DBG_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_data  <= w_data_next;
    end
  end

  // The next beat is captured with bypass so a write landing on the accept edge is seen.
  assign w_nxt_addr = r_idx + 1'b1;
  assign w_nxt_data = (i_we == WriteEnable && i_waddr == w_nxt_addr) ? i_wdata
                                                                     : r_regs[w_nxt_addr];

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_data_next  = r_data;
    o_dbg_busy   = 1'b0;
    o_dbg_valid  = 1'b0;
    o_dbg_done   = 1'b0;
    case (r_state)
      DBG_IDLE: begin
        if (i_dbg_start) begin
          w_state_next = DBG_SEND;
          w_idx_next   = '0;
          w_data_next  = DATA_W'(ZeroWord);
        end
      end
      DBG_SEND: begin
        o_dbg_busy  = 1'b1;
        o_dbg_valid = 1'b1;
        if (i_dbg_ready) begin
          if (r_idx == ADDR_W'(NREG - 1)) begin
            w_state_next = DBG_DONE;
          end else begin
            w_idx_next  = w_nxt_addr;
            w_data_next = w_nxt_data;
          end
        end
      end
      DBG_DONE: begin
        o_dbg_done   = 1'b1;
        w_state_next = DBG_IDLE;
        w_idx_next   = '0;
        w_data_next  = DATA_W'(ZeroWord);
      end
      default: w_state_next = DBG_IDLE;
    endcase
  end

  assign o_dbg_addr = r_idx;
  assign o_dbg_data = r_data;

endmodule

// File: tb/tb_regfile_dbg.sv
// Randomized scoreboard bench for regfile_dbg against an array-based register/dump model.
module tb_regfile_dbg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        dbg_start, dbg_busy, dbg_valid, dbg_ready, dbg_done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  regfile_dbg dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .i_re1       (re1),
    .i_raddr1    (raddr1),
    .o_rdata1    (rdata1),
    .i_re2       (re2),
    .i_raddr2    (raddr2),
    .o_rdata2    (rdata2),
    .i_dbg_start (dbg_start),
    .o_dbg_busy  (dbg_busy),
    .o_dbg_valid (dbg_valid),
    .i_dbg_ready (dbg_ready),
    .o_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data),
    .o_dbg_done  (dbg_done)
  );

  typedef struct {int port; logic [31:0] exp;} rd_t;
  typedef struct {logic [4:0] a; logic [31:0] d;} beat_t;

  rd_t   rd_q[$];
  beat_t beat_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc_cnt = 0;
  int t_start = 0;
  bit lat_chk = 0;
  bit done_seen = 0;

  // Model: register contents and dump progress, advanced once per clock from the bench's own inputs.
  logic [31:0] m_mem [32];
  bit          m_send, m_done;
  int          m_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_send = 0;
      m_done = 0;
      m_idx  = 0;
      beat_q.delete();
    end else begin
      bit load;
      load = 0;
      if (we && waddr != 5'd0) m_mem[waddr] = wdata;
      if (m_done) begin
        m_done = 0;
      end else if (m_send) begin
        if (dbg_ready) begin
          if (m_idx == 31) begin
            m_send = 0;
            m_done = 1;
          end else begin
            m_idx++;
            load = 1;
          end
        end
      end else if (dbg_start) begin
        m_send = 1;
        m_idx  = 0;
        load   = 1;
      end
      if (load) beat_q.push_back('{5'(m_idx), m_mem[m_idx]});
    end
  end

  always @(negedge clk) begin
    while (rd_q.size() > 0) begin
      rd_t r;
      r = rd_q.pop_front();
      if (r.port == 1) chk("rdata1", rdata1, r.exp);
      else             chk("rdata2", rdata2, r.exp);
    end
    if (dbg_valid || m_send) begin
      chk("dbg_valid", 32'(dbg_valid), 32'(m_send));
      chk("dbg_busy", 32'(dbg_busy), 32'(m_send));
      if (m_send) begin
        if (beat_q.size() == 0) begin
          chk("beat_queue_empty", 32'(beat_q.size()), 32'd1);
        end else begin
          chk("dbg_addr", 32'(dbg_addr), 32'(beat_q[0].a));
          chk("dbg_data", dbg_data, beat_q[0].d);
          if (dbg_ready) void'(beat_q.pop_front());
        end
      end
    end
    if (dbg_done || m_done) begin
      chk("dbg_done", 32'(dbg_done), 32'(m_done));
      chk("busy_in_done", 32'(dbg_busy), 32'd0);
      if (dbg_done) begin
        done_seen = 1;
        if (lat_chk) begin
          chk("done_latency", 32'(cyc_cnt - t_start), 32'd33);
          lat_chk = 0;
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                       input logic st, input logic rdy);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    dbg_start = st; dbg_ready = rdy;
    rd_q.push_back('{1, exp_rd(re1, raddr1)});
    rd_q.push_back('{2, exp_rd(re2, raddr2)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                     input logic st, input logic rdy);
    drive(w, wa, wd, r1, a1, r2, a2, st, rdy);
    step();
  endtask

  task automatic rand_cyc(input logic st, input bit rand_rdy);
    cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
        1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
        st, rand_rdy ? 1'($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int k = 0; k < budget && !done_seen; k++) begin
      if (rnd) rand_cyc(1'b0, 1'b1);
      else cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    end
    chk("dump_completed", 32'(done_seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 1'b0);
    #2;
    chk("rst_busy", 32'(dbg_busy), 32'd0);
    chk("rst_valid", 32'(dbg_valid), 32'd0);
    chk("rst_addr", 32'(dbg_addr), 32'd0);
    chk("rst_data", dbg_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);

    cyc(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);

    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    for (int i = 1; i < 32; i++)
      cyc(1'b1, 5'(i), 32'(i * 32'h11), 1'b1, 5'($urandom_range(0, 31)), 1'b1, 5'(i), 1'b0, 1'b0);
    done_seen = 0;
    t_start = cyc_cnt;
    lat_chk = 1;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    wait_done(60, 1'b0);

    done_seen = 0;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int j = 1; j <= 3; j++) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int j = 4; j <= 7; j++)
      cyc(j == 5, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd4, 32'hC0FFEE04, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    wait_done(60, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);

    done_seen = 0;
    rand_cyc(1'b1, 1'b0);
    wait_done(300, 1'b1);

    done_seen = 0;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int j = 1; j <= 10; j++) cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2;
    chk("pre_rst_addr", 32'(dbg_addr), 32'd10);
    rst = 1'b1;
    re1 = 1'b1;
    raddr1 = 5'd5;
    #1;
    chk("midrst_valid", 32'(dbg_valid), 32'd0);
    chk("midrst_busy", 32'(dbg_busy), 32'd0);
    chk("midrst_addr", 32'(dbg_addr), 32'd0);
    chk("midrst_rdata1", rdata1, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'(5 + j), 1'b1, 5'(31 - j), 1'b0, 1'b1);
    chk("no_done_after_rst", 32'(done_seen), 32'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    wait_done(60, 1'b1);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_dbg.md
Name: regfile_dbg

Overview:
- General-purpose register file that answers the decode stage's two read requests and accepts the write-back stage's single write.
- Reads are combinational and serve decode in the same cycle. A write in the same cycle is forwarded to the read ports.
- A debug dump engine streams all registers out over a valid/ready handshake for bring-up and test.

Parameters:
DATA_W, 32, register width (matches RegBus)
ADDR_W, 5, register index width (matches RegAddrBus)
NREG, 32, number of registers; index 0 hardwired to zero

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
we  in  1  write-back write enable
waddr  in  ADDR_W  write-back destination register
wdata  in  DATA_W  write-back data
re1  in  1  read-port-1 enable from decode
raddr1  in  ADDR_W  read-port-1 address
rdata1  out  DATA_W  read-port-1 data, combinational
re2  in  1  read-port-2 enable from decode
raddr2  in  ADDR_W  read-port-2 address
rdata2  out  DATA_W  read-port-2 data, combinational
dbg_start  in  1  single-cycle request to begin a dump
dbg_busy  out  1  dump in progress
dbg_valid  out  1  dump beat valid
dbg_ready  in  1  consumer accepts beat
dbg_addr  out  ADDR_W  index of current beat
dbg_data  out  DATA_W  value of current beat
dbg_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset is asynchronous and active-high on rst; the single clock is clk.
  - While rst=1: all NREG registers = 0; FSM = IDLE; dbg_busy, dbg_valid and dbg_done = 0; dbg_addr and dbg_data = 0.
  - rdata1 and rdata2 = 0 while rst=1.
- Write: on the clk rising edge, if we=1 and waddr!=0, then reg[waddr] <= wdata. Writes to index 0 are discarded.
- Read port n (priority order, purely combinational, zero latency):
  - rst=1 or ren=0 -> 0
  - raddrn=0 -> 0
  - we=1 and waddr==raddrn -> wdata (write-through bypass)
  - otherwise -> reg[raddrn]
- Both ports may read the same address at once; each follows its own rule independently.
- Debug FSM states: IDLE, SEND, DONE.
  - IDLE:
    - dbg_start=1 -> SEND. Set idx=0 and load dbg_data = current value of reg[0], which is 0.
    - dbg_start is ignored in SEND and DONE.
  - SEND:
    - dbg_valid=1, dbg_busy=1, dbg_addr=idx.
    - While dbg_ready=0: dbg_addr and dbg_data stay stable (per-beat snapshot). A write to reg[idx] during the stall does not alter dbg_data; the register itself is still updated.
    - On dbg_valid and dbg_ready with idx<NREG-1: idx <= idx+1. dbg_data <= the bypassed value of reg[idx+1], so a same-edge write to idx+1 is captured.
    - On dbg_valid and dbg_ready with idx==NREG-1 -> DONE.
  - DONE: dbg_done=1 for exactly one cycle, dbg_busy=0, dbg_valid=0; then -> IDLE.
- Throughput: one beat per cycle with dbg_ready held at 1. Latency from dbg_start to the DONE cycle = NREG+1 cycles minimum.
- Reads, writes and the dump run concurrently with no mutual stalls.
- rst asserted mid-dump: immediate return to IDLE; no dbg_done pulse.
- idx wraps only via the DONE path; it never exceeds NREG-1.

Decomposition:
- Shared package / defines file holds:
  - Existing RegBus, RegAddrBus, RstEnable, WriteEnable, ZeroWord, NOPRegAddr.
  - New: RegNum=32, RegNumLog2=5, and the dump state encodings DBG_IDLE, DBG_SEND, DBG_DONE.
- One natural sub-module: regfile_rdport, the per-port combinational read/bypass mux. It is instantiated twice.
- The dump engine stays inline in regfile_dbg.

Test Plan:
1. Reset then read: release rst, re1=1 raddr1=5 -> rdata1=0. Write reg5=0xDEADBEEF, next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF.
2. Bypass: same cycle we=1 waddr=7 wdata=0x12345678, re2=1 raddr2=7 -> rdata2=0x12345678 before the edge. re2=0 -> rdata2=0.
3. Register zero: we=1 waddr=0 wdata=0xFFFFFFFF, then re1=1 raddr1=0 -> rdata1=0. The dump reports beat 0 as 0.
4. Full dump:
   - Preload reg[i]=i*0x11 for i=1..31; pulse dbg_start with dbg_ready=1.
   - Expect 32 consecutive beats, addr 0..31, data 0, 0x11, ..., 0x20F.
   - Then dbg_done=1 for one cycle, 33 cycles after dbg_start.
5. Backpressure:
   - During a dump, hold dbg_ready=0 at beat 3 for 4 cycles while writing reg3=0xAAAA5555.
   - Expect dbg_addr=3 and dbg_data=0x33 stable throughout; later rdata1 for addr 3 = 0xAAAA5555.
   - Also check that a write to reg4 on the accept edge appears as beat-4 data.
6. Reset mid-dump: assert rst at beat 10 -> dbg_valid, dbg_busy and dbg_addr drop to 0 asynchronously and all registers read 0. There is no dbg_done pulse. A dbg_start after release restarts from addr 0.
